// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
// Holds the data-mode and FSM state enums plus the LFSR feedback polynomial.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_RAND  = 2'd1,
        MODE_CONST = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_GAP,
        S_DONE
    } state_e;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/axis_pkt_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous reload of SEED and a per-beat advance enable.
// Load takes priority over advance so a new run always starts from SEED.
module axis_pkt_gen_lfsr
    import axis_pkt_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: ramp, LFSR or constant packets with programmable
// length, packet count and inter-packet gap; config is latched on start.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int          DWIDTH = 64,
    parameter int          LEN_W  = 16,
    parameter logic [31:0] SEED   = 32'hACE1_1234
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [LEN_W-1:0]  num_pkts,
    input  logic [LEN_W-1:0]  gap_cycles,
    input  logic [DWIDTH-1:0] ramp_start,
    input  logic [DWIDTH-1:0] ramp_inc,
    output logic [DWIDTH-1:0] o_tdata,
    output logic              o_tvalid,
    output logic              o_tlast,
    input  logic              o_tready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  pkt_count
);

    localparam int REPS = (DWIDTH + 31) / 32;

    state_e             state, state_n;
    mode_e              mode_q;
    logic [LEN_W-1:0]   len_m1, num_q, gap_q, beat_cnt, gap_cnt;
    logic [DWIDTH-1:0]  const_q, inc_q, ramp_acc, rand_word;
    logic [REPS*32-1:0] rand_rep;
    logic [31:0]        lfsr_q;
    logic               stop_pend, start_ok, beat_fire, last_fire, target_hit;

    assign start_ok   = (state == S_IDLE) && start;
    assign o_tvalid   = (state == S_DATA);
    assign o_tlast    = o_tvalid && (beat_cnt == len_m1);
    assign beat_fire  = o_tvalid && o_tready;
    assign last_fire  = beat_fire && o_tlast;
    assign target_hit = (num_q != '0) && (pkt_count == num_q - 1'b1);
    assign busy       = (state == S_DATA) || (state == S_GAP);
    assign done       = (state == S_DONE);

    axis_pkt_gen_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .advance (beat_fire),
        .state   (lfsr_q)
    );

    assign rand_rep  = {REPS{lfsr_q}};
    assign rand_word = rand_rep[DWIDTH-1:0];

    // Data is a function of registered state only, so it holds while stalled
    always_comb begin
        o_tdata = '0;
        if (o_tvalid) begin
            case (mode_q)
                MODE_RAND:  o_tdata = rand_word;
                MODE_CONST: o_tdata = const_q;
                default:    o_tdata = ramp_acc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_DATA;
            end
            S_DATA: begin
                if (last_fire) begin
                    if (target_hit || stop_pend || stop) state_n = S_DONE;
                    else if (gap_q != '0)                state_n = S_GAP;
                    else                                 state_n = S_DATA;
                end
            end
            S_GAP: begin
                if (stop || stop_pend)   state_n = S_DONE;
                else if (gap_cnt == '0)  state_n = S_DATA;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_RAMP;
            len_m1    <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            const_q   <= '0;
            inc_q     <= '0;
            ramp_acc  <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pkt_count <= '0;
            stop_pend <= 1'b0;
        end else if (start_ok) begin
            case (mode)
                2'd1:    mode_q <= MODE_RAND;
                2'd2:    mode_q <= MODE_CONST;
                default: mode_q <= MODE_RAMP;
            endcase
            len_m1    <= (pkt_len == '0) ? '0 : pkt_len - 1'b1;
            num_q     <= num_pkts;
            gap_q     <= gap_cycles;
            const_q   <= ramp_start;
            inc_q     <= ramp_inc;
            ramp_acc  <= ramp_start;
            beat_cnt  <= '0;
            pkt_count <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (stop && busy) stop_pend <= 1'b1;
            // Ramp index runs across packets; only start rewinds it
            if (beat_fire) begin
                ramp_acc <= ramp_acc + inc_q;
                beat_cnt <= o_tlast ? '0 : beat_cnt + 1'b1;
            end
            if (last_fire) begin
                pkt_count <= pkt_count + 1'b1;
                gap_cnt   <= gap_q - 1'b1;
            end else if ((state == S_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed and randomized runs compared
// against an expected-beat list built from the packet rules.
module tb_axis_pkt_gen;

    localparam int          DW      = 64;
    localparam int          LW      = 16;
    localparam logic [31:0] SEED_TB = 32'hACE1_1234;
    localparam logic [31:0] POLY    = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, stop;
    logic [1:0]    mode;
    logic [LW-1:0] pkt_len, num_pkts, gap_cycles;
    logic [DW-1:0] ramp_start, ramp_inc;
    logic [DW-1:0] o_tdata;
    logic          o_tvalid, o_tlast, o_tready;
    logic          busy, done;
    logic [LW-1:0] pkt_count;

    axis_pkt_gen #(
        .DWIDTH(DW),
        .LEN_W (LW),
        .SEED  (SEED_TB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .pkt_len    (pkt_len),
        .num_pkts   (num_pkts),
        .gap_cycles (gap_cycles),
        .ramp_start (ramp_start),
        .ramp_inc   (ramp_inc),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tlast    (o_tlast),
        .o_tready   (o_tready),
        .busy       (busy),
        .done       (done),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    logic [DW-1:0] cap_d[$];
    bit            cap_l[$];
    bit            vlog[$];
    logic [LW-1:0] done_pc;
    logic          done_busy;
    bit            timed_out;
    int            stall_cnt, hold_bad;

    function automatic logic [DW-1:0] rep32(input logic [31:0] s);
        logic [DW-1:0] r = '0;
        for (int k = 0; k < (DW + 31) / 32; k++) r |= DW'(s) << (32 * k);
        return r;
    endfunction

    // Expected beats: beat n of the run carries start+n*inc (ramp), the n-th LFSR
    // state from SEED (random) or the constant; tlast on the final beat of each packet.
    task automatic build_exp(input logic [1:0] m, input int len, input int num,
                             input logic [DW-1:0] rs, input logic [DW-1:0] ri);
        int            l = (len == 0) ? 1 : len;
        logic [31:0]   s = SEED_TB;
        logic [DW-1:0] n;
        exp_d.delete();
        exp_l.delete();
        for (int p = 0; p < num; p++) begin
            for (int b = 0; b < l; b++) begin
                n = DW'(p * l + b);
                case (m)
                    2'd1:    exp_d.push_back(rep32(s));
                    2'd2:    exp_d.push_back(rs);
                    default: exp_d.push_back(rs + n * ri);
                endcase
                s = (s >> 1) ^ (s[0] ? POLY : 32'h0);
                exp_l.push_back(b == l - 1);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; o_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Applies config with a one-cycle start, then scrambles the config inputs
    task automatic start_gen(input logic [1:0] m, input int len, input int num, input int gap,
                             input logic [DW-1:0] rs, input logic [DW-1:0] ri, input bit with_stop);
        mode = m; pkt_len = LW'(len); num_pkts = LW'(num); gap_cycles = LW'(gap);
        ramp_start = rs; ramp_inc = ri;
        start = 1'b1; stop = with_stop;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
        mode = 2'($urandom); pkt_len = LW'($urandom); num_pkts = LW'($urandom);
        gap_cycles = LW'($urandom); ramp_start = {$urandom, $urandom}; ramp_inc = {$urandom, $urandom};
    endtask

    // rmode: 0 ready high, 1 toggling 1010.., 2 random. Runs until done or budget.
    task automatic capture(input int rmode, input int stop_beat, input bit stop_gap, input int max_cyc);
        int            beats = 0, cyc = 0;
        bit            stall = 0, gap_stopped = 0, got_done = 0;
        logic [DW-1:0] pd;
        logic          pl;
        cap_d.delete(); cap_l.delete(); vlog.delete();
        stall_cnt = 0; hold_bad = 0;
        while (!got_done && cyc < max_cyc) begin
            case (rmode)
                0:       o_tready = 1'b1;
                1:       o_tready = (cyc % 2 == 0);
                default: o_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            vlog.push_back(o_tvalid);
            if (stall) begin
                stall_cnt++;
                if (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl) hold_bad++;
            end
            stall = o_tvalid && !o_tready;
            pd = o_tdata; pl = o_tlast;
            if (o_tvalid && o_tready) begin
                cap_d.push_back(o_tdata);
                cap_l.push_back(o_tlast);
                beats++;
                if (beats == stop_beat) stop = 1'b1;
            end
            if (stop_gap && !gap_stopped && beats > 0 && !o_tvalid && !done) begin
                stop = 1'b1;
                gap_stopped = 1;
            end
            if (done) begin
                got_done = 1;
                done_pc = pkt_count;
                done_busy = busy;
            end
            cyc++;
            @(posedge clk);
            #1 stop = 1'b0;
        end
        timed_out = !got_done;
        if (timed_out) do_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid got=%b exp=0", o_tvalid); end
        n_cmp++; if (o_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast got=%b exp=0", o_tlast); end
        n_cmp++; if (o_tdata !== '0) begin n_bad++; $display("FAIL rst_tdata got=%h exp=0", o_tdata); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
        n_cmp++; if (pkt_count !== '0) begin n_bad++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_rst got=%b%b exp=00", o_tvalid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp_basic();
        build_exp(2'd0, 4, 2, '0, 64'd1);
        start_gen(2'd0, 4, 2, 0, '0, 64'd1, 0);
        capture(0, 0, 0, 400);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ramp_timeout got=no_done exp=done"); end
        n_cmp++; if (cap_d.size() !== exp_d.size()) begin
            n_bad++; $display("FAIL ramp_beats got=%0d exp=%0d", cap_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL ramp_beat%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        // First beat the cycle after start, one beat per cycle, then the done cycle
        n_cmp++; if (vlog.size() !== 9) begin n_bad++; $display("FAIL ramp_cycles got=%0d exp=9", vlog.size()); end
        for (int i = 0; i < vlog.size(); i++) begin
            n_cmp++; if (vlog[i] !== (i < 8)) begin
                n_bad++; $display("FAIL ramp_valid%0d got=%b exp=%b", i, vlog[i], (i < 8));
            end
        end
        n_cmp++; if (done_pc !== 16'd2) begin n_bad++; $display("FAIL ramp_pkt_count got=%0d exp=2", done_pc); end
        n_cmp++; if (done_busy !== 1'b0) begin n_bad++; $display("FAIL ramp_busy_at_done got=%b exp=0", done_busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || o_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL ramp_after_done got=%b%b%b exp=000", done, busy, o_tvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        build_exp(2'd0, 4, 2, '0, 64'd1);
        start_gen(2'd0, 4, 2, 0, '0, 64'd1, 0);
        capture(1, 0, 0, 400);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL stall_timeout got=no_done exp=done"); end
        n_cmp++; if (cap_d.size() !== exp_d.size()) begin
            n_bad++; $display("FAIL stall_beats got=%0d exp=%0d", cap_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++; if (stall_cnt < 1) begin n_bad++; $display("FAIL stall_seen got=%0d exp=>0", stall_cnt); end
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL stall_hold got=%0d exp=0", hold_bad); end
        n_cmp++; if (done_pc !== 16'd2) begin n_bad++; $display("FAIL stall_pkt_count got=%0d exp=2", done_pc); end
    endtask

    task automatic test_gap();
        bit ev[$] = '{1, 1, 0, 0, 0, 1, 1, 0};
        start_gen(2'd0, 2, 2, 3, 64'd10, 64'd5, 0);
        capture(0, 0, 0, 400);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL gap_timeout got=no_done exp=done"); end
        n_cmp++; if (vlog.size() !== ev.size()) begin
            n_bad++; $display("FAIL gap_cycles got=%0d exp=%0d", vlog.size(), ev.size());
        end
        for (int i = 0; i < ev.size() && i < vlog.size(); i++) begin
            n_cmp++; if (vlog[i] !== ev[i]) begin
                n_bad++; $display("FAIL gap_valid%0d got=%b exp=%b", i, vlog[i], ev[i]);
            end
        end
        n_cmp++; if (cap_d.size() !== 4 || cap_d[2] !== 64'd20) begin
            n_bad++; $display("FAIL gap_data got=%0d beats exp=4 with beat2=20", cap_d.size());
        end
    endtask

    task automatic test_rand_repeat();
        build_exp(2'd1, 5, 2, '0, '0);
        for (int run = 0; run < 2; run++) begin
            start_gen(2'd1, 5, 2, 1, '0, '0, 0);
            capture(2, 0, 0, 400);
            n_cmp++; if (timed_out) begin n_bad++; $display("FAIL rand_timeout run%0d", run); end
            n_cmp++; if (cap_d.size() !== exp_d.size()) begin
                n_bad++; $display("FAIL rand_beats run%0d got=%0d exp=%0d", run, cap_d.size(), exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
                n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                    n_bad++; $display("FAIL rand_beat%0d run%0d got=%h/%b exp=%h/%b", i, run, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_stop();
        build_exp(2'd0, 3, 2, 64'd7, 64'd3);
        start_gen(2'd0, 3, 0, 0, 64'd7, 64'd3, 0);
        capture(2, 4, 0, 400);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL stop_timeout got=no_done exp=done"); end
        n_cmp++; if (cap_d.size() !== exp_d.size()) begin
            n_bad++; $display("FAIL stop_beats got=%0d exp=%0d", cap_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL stop_beat%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++; if (done_pc !== 16'd2) begin n_bad++; $display("FAIL stop_pkt_count got=%0d exp=2", done_pc); end
    endtask

    task automatic test_stop_gap();
        start_gen(2'd0, 2, 0, 4, '0, 64'd1, 0);
        capture(0, 0, 1, 400);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL stopgap_timeout got=no_done exp=done"); end
        n_cmp++; if (vlog.size() !== 4 || cap_d.size() !== 2) begin
            n_bad++; $display("FAIL stopgap_cycles got=%0d/%0d exp=4/2", vlog.size(), cap_d.size());
        end
        n_cmp++; if (done_pc !== 16'd1) begin n_bad++; $display("FAIL stopgap_pkt_count got=%0d exp=1", done_pc); end
    endtask

    task automatic test_start_stop();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || o_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL idle_stop got=%b%b exp=00", busy, o_tvalid);
        end
        @(posedge clk); #1;
        build_exp(2'd0, 2, 2, 64'd100, 64'd3);
        start_gen(2'd0, 2, 2, 0, 64'd100, 64'd3, 1);
        capture(0, 0, 0, 400);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL startstop_timeout got=no_done exp=done"); end
        n_cmp++; if (cap_d.size() !== exp_d.size()) begin
            n_bad++; $display("FAIL startstop_beats got=%0d exp=%0d", cap_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                n_bad++; $display("FAIL startstop_beat%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_cmp++; if (done_pc !== 16'd2) begin n_bad++; $display("FAIL startstop_pkt_count got=%0d exp=2", done_pc); end
    endtask

    task automatic test_len0_wrap();
        build_exp(2'd0, 0, 3, 64'd9, 64'd1);
        start_gen(2'd0, 0, 3, 0, 64'd9, 64'd1, 0);
        capture(0, 0, 0, 400);
        n_cmp++; if (cap_d.size() !== 3) begin n_bad++; $display("FAIL len0_beats got=%0d exp=3", cap_d.size()); end
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== 1'b1) begin
                n_bad++; $display("FAIL len0_beat%0d got=%h/%b exp=%h/1", i, cap_d[i], cap_l[i], exp_d[i]);
            end
        end
        start_gen(2'd3, 3, 1, 0, '1, 64'd2, 0);
        capture(0, 0, 0, 400);
        n_cmp++; if (cap_d.size() !== 3) begin n_bad++; $display("FAIL wrap_beats got=%0d exp=3", cap_d.size()); end
        else begin
            n_cmp++; if (cap_d[0] !== {DW{1'b1}} || cap_d[1] !== 64'd1 || cap_d[2] !== 64'd3) begin
                n_bad++; $display("FAIL wrap_data got=%h,%h,%h exp=ff..ff,1,3", cap_d[0], cap_d[1], cap_d[2]);
            end
        end
    endtask

    task automatic test_random_cfg();
        for (int it = 0; it < 8; it++) begin
            logic [1:0]    m   = 2'($urandom_range(0, 3));
            int            len = $urandom_range(0, 6);
            int            num = $urandom_range(1, 3);
            int            gap = $urandom_range(0, 3);
            logic [DW-1:0] rs  = {$urandom, $urandom};
            logic [DW-1:0] ri  = {$urandom, $urandom};
            build_exp(m, len, num, rs, ri);
            start_gen(m, len, num, gap, rs, ri, 0);
            capture(2, 0, 0, 600);
            n_cmp++; if (timed_out) begin n_bad++; $display("FAIL rnd%0d_timeout got=no_done exp=done", it); end
            n_cmp++; if (cap_d.size() !== exp_d.size()) begin
                n_bad++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", it, cap_d.size(), exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
                n_cmp++; if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
                    n_bad++; $display("FAIL rnd%0d_beat%0d got=%h/%b exp=%h/%b", it, i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
                end
            end
            n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_hold got=%0d exp=0", it, hold_bad); end
            n_cmp++; if (done_pc !== LW'(num)) begin
                n_bad++; $display("FAIL rnd%0d_pkt_count got=%0d exp=%0d", it, done_pc, num);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_gen(2'd0, 20, 1, 0, 64'd50, 64'd1, 0);
        o_tready = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_tdata !== '0) begin
            n_bad++; $display("FAIL midrst_out got=%b%b/%h exp=00/0", o_tvalid, o_tlast, o_tdata);
        end
        n_cmp++; if (busy !== 1'b0 || pkt_count !== '0) begin
            n_bad++; $display("FAIL midrst_status got=%b/%0d exp=0/0", busy, pkt_count);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got=%b exp=0", o_tvalid); end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; o_tready = 1'b0;
        mode = '0; pkt_len = '0; num_pkts = '0; gap_cycles = '0;
        ramp_start = '0; ramp_inc = '0;
        test_reset();
        test_ramp_basic();
        test_stall();
        test_gap();
        test_rand_repeat();
        test_stop();
        test_stop_gap();
        test_start_stop();
        test_len0_wrap();
        test_random_cfg();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
